ultrasonic_ranger: RTL and testbench



---
 rtl/ranger_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 33 +++
 rtl/ultrasonic_ranger.sv | 197 +++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ranger_pkg.sv
// rtl/ranger_pkg.sv - shared types and constants for the ultrasonic ranger
//
// Purpose: FSM state encoding, the far/saturated distance value, the default
// cycle counts for a 50 MHz clock, and a max helper used to size counters.
// Ports: none (package).

package ranger_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_RISE = 3'd2,
      MEASURE   = 3'd3,
      HOLDOFF   = 3'd4
   } ranger_state_e;

   localparam logic [7:0] DIST_MAX = 8'd255;

   // 50 MHz defaults
   localparam int unsigned DEF_TRIG_CYCLES         = 500;        // 10 us
   localparam int unsigned DEF_CYCLES_PER_UNIT     = 2900;       // 58 us per cm
   localparam int unsigned DEF_ECHO_TIMEOUT_CYCLES = 1_500_000;
   localparam int unsigned DEF_MAX_ECHO_CYCLES     = 1_900_000;
   localparam int unsigned DEF_HOLDOFF_CYCLES      = 3_000_000;  // 60 ms

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
//
// Purpose: brings an asynchronous level into the clk domain; q_o lags d_i by
// two clock edges. Resets to 0.
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset
//   d_i    in   asynchronous input level
//   q_o    out  synchronized level

module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - HC-SR04-style trigger/echo ranging controller
//
// Purpose: pulses trig, times the echo-high width and converts it to a
// distance in sensor units (floor(high cycles / CYCLES_PER_UNIT), saturating
// at 255). Runs continuously while enable is high with a holdoff gap between
// measurements.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   enable    in   run continuous measurements while high
//   echo      in   raw sensor echo, asynchronous to clk
//   trig      out  registered sensor trigger pulse
//   distance  out  last measured distance, held; 255 on timeout and after reset
//   valid     out  one-cycle strobe when distance/timeout update
//   timeout   out  last measurement timed out, held
//   busy      out  FSM is not IDLE

module ultrasonic_ranger
   import ranger_pkg::*;
#(
   parameter int unsigned TRIG_CYCLES         = DEF_TRIG_CYCLES,
   parameter int unsigned CYCLES_PER_UNIT     = DEF_CYCLES_PER_UNIT,
   parameter int unsigned ECHO_TIMEOUT_CYCLES = DEF_ECHO_TIMEOUT_CYCLES,
   parameter int unsigned MAX_ECHO_CYCLES     = DEF_MAX_ECHO_CYCLES,
   parameter int unsigned HOLDOFF_CYCLES      = DEF_HOLDOFF_CYCLES
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       echo,
   output logic       trig,
   output logic [7:0] distance,
   output logic       valid,
   output logic       timeout,
   output logic       busy
);

   localparam int unsigned CNT_MAX = max_u(max_u(max_u(TRIG_CYCLES, CYCLES_PER_UNIT),
                                                 max_u(ECHO_TIMEOUT_CYCLES, MAX_ECHO_CYCLES)),
                                           HOLDOFF_CYCLES);
   localparam int CNT_W = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CYCLES_PER_UNIT - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HIGH_LIMIT = CNT_W'(MAX_ECHO_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

   ranger_state_e    state_q;
   logic [CNT_W-1:0] cnt_q;       // trigger width, rise wait and holdoff
   logic [CNT_W-1:0] high_q;      // echo-high cycles in the current measurement
   logic [CNT_W-1:0] presc_q;
   logic [7:0]       unit_q;
   logic             echo_prev_q;
   logic             trig_q;
   logic [7:0]       dist_q;
   logic             valid_q;
   logic             timeout_q;
   logic             busy_q;

   logic             echo_s;
   logic             echo_rise;
   logic [CNT_W-1:0] presc_base;
   logic [7:0]       unit_base;
   logic [CNT_W-1:0] presc_d;
   logic [7:0]       unit_d;
   logic [CNT_W-1:0] high_d;

   sync_2ff u_echo_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .d_i   (echo),
      .q_o   (echo_s)
   );

   // Only a fresh rise starts a measurement; a level still high from an
   // earlier, timed-out echo must not.
   assign echo_rise = echo_s & ~echo_prev_q;

   // The cycle that detects the rise is itself the first high cycle, so the
   // count steps from zero there and from the running values in MEASURE.
   always_comb begin
      presc_base = '0;
      unit_base  = '0;
      high_d     = CNT_W'(1);
      if (state_q == MEASURE) begin
         presc_base = presc_q;
         unit_base  = unit_q;
         high_d     = high_q + 1'b1;
      end
      presc_d = presc_base + 1'b1;
      unit_d  = unit_base;
      if (presc_base == PRESC_LAST) begin
         presc_d = '0;
         unit_d  = (unit_base == DIST_MAX) ? unit_base : unit_base + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         high_q      <= '0;
         presc_q     <= '0;
         unit_q      <= '0;
         echo_prev_q <= 1'b0;
         trig_q      <= 1'b0;
         dist_q      <= DIST_MAX;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         valid_q     <= 1'b0;
         echo_prev_q <= echo_s;
         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_q <= TRIG;
                  trig_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            TRIG: begin
               if (cnt_q == TRIG_LAST) begin
                  state_q <= WAIT_RISE;
                  trig_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_RISE: begin
               if (echo_rise) begin
                  state_q <= MEASURE;
                  presc_q <= presc_d;
                  unit_q  <= unit_d;
                  high_q  <= high_d;
               end else if (cnt_q == WAIT_LAST) begin
                  state_q   <= HOLDOFF;
                  cnt_q     <= '0;
                  dist_q    <= DIST_MAX;
                  timeout_q <= 1'b1;
                  valid_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            MEASURE: begin
               if (!echo_s) begin
                  state_q   <= HOLDOFF;
                  cnt_q     <= '0;
                  dist_q    <= unit_q;
                  timeout_q <= 1'b0;
                  valid_q   <= 1'b1;
               end else if (high_d >= HIGH_LIMIT) begin
                  state_q   <= HOLDOFF;
                  cnt_q     <= '0;
                  dist_q    <= DIST_MAX;
                  timeout_q <= 1'b1;
                  valid_q   <= 1'b1;
               end else begin
                  presc_q <= presc_d;
                  unit_q  <= unit_d;
                  high_q  <= high_d;
               end
            end
            HOLDOFF: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_q <= '0;
                  if (enable) begin
                     state_q <= TRIG;
                     trig_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               trig_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign trig     = trig_q;
   assign distance = dist_q;
   assign valid    = valid_q;
   assign timeout  = timeout_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb/tb_ultrasonic_ranger.sv - self-checking bench for ultrasonic_ranger

module tb_ultrasonic_ranger;

   localparam int TRIG = 4;
   localparam int CPU  = 10;
   localparam int TO   = 50;
   localparam int MAXE = 3000;
   localparam int HO   = 20;
   localparam int MAXT = 8192;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       echo = 1'b0;
   logic       trig;
   logic [7:0] distance;
   logic       valid;
   logic       timeout;
   logic       busy;

   ultrasonic_ranger #(
      .TRIG_CYCLES         (TRIG),
      .CYCLES_PER_UNIT     (CPU),
      .ECHO_TIMEOUT_CYCLES (TO),
      .MAX_ECHO_CYCLES     (MAXE),
      .HOLDOFF_CYCLES      (HO)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .echo     (echo),
      .trig     (trig),
      .distance (distance),
      .valid    (valid),
      .timeout  (timeout),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // stimulus per cycle (applied during cycle c, sampled at edge c+1)
   bit         en_a   [MAXT];
   bit         echo_a [MAXT];
   // expected outputs visible during cycle c
   bit         exp_trig  [MAXT];
   bit         exp_busy  [MAXT];
   bit         exp_valid [MAXT];
   bit         exp_to    [MAXT];
   logic [7:0] exp_dist  [MAXT];
   int         w0_q[$];
   int         vc_q[$];

   // observed DUT events
   int dut_vc[$];
   int dut_d[$];
   int dut_t[$];
   int rise_q[$];
   int fall_q[$];

   int cyc = 0;
   bit checking = 1'b0;
   bit prev_trig = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // synchronized echo as the controller sees it during cycle c
   function automatic bit es(input int c);
      if (c < 2 || c - 2 >= MAXT) return 1'b0;
      return echo_a[c - 2];
   endfunction

   // Phase-level model: find trigger windows, rise windows and echo widths
   // directly on the stimulus arrays and paint the expected outputs.
   task automatic run_model(input int T);
      int c, k, ts, w0, j, m, v, nxt, n;
      bit found, running;
      logic [7:0] nd;
      bit nt;
      w0_q.delete();
      vc_q.delete();
      for (int i = 0; i < MAXT; i++) begin
         exp_trig[i] = 0; exp_busy[i] = 0; exp_valid[i] = 0;
         exp_to[i] = 0; exp_dist[i] = 8'd255;
      end
      c = 0;
      nxt = 0;
      while (c < T) begin
         k = c;
         while (k < T && !en_a[k]) k++;
         if (k >= T) break;
         ts = k + 1;
         running = 1;
         while (running && ts < T) begin
            for (int i = ts; i < ts + TRIG && i < T; i++) begin
               exp_trig[i] = 1; exp_busy[i] = 1;
            end
            w0 = ts + TRIG;
            w0_q.push_back(w0);
            found = 0;
            j = w0;
            for (int i = w0; i < w0 + TO; i++)
               if (!found && es(i) && !es(i - 1)) begin found = 1; j = i; end
            if (found) begin
               m = j;
               while (m < j + MAXE && es(m)) m++;
               n = m - j;
               if (n >= MAXE) begin
                  v = j + MAXE; nd = 8'd255; nt = 1;
               end else begin
                  v = m + 1; nd = (n / CPU > 255) ? 8'd255 : 8'(n / CPU); nt = 0;
               end
            end else begin
               v = w0 + TO; nd = 8'd255; nt = 1;
            end
            for (int i = w0; i < v + HO && i < T; i++) exp_busy[i] = 1;
            if (v < T) begin
               exp_valid[v] = 1;
               vc_q.push_back(v);
               for (int i = v; i < T; i++) begin exp_dist[i] = nd; exp_to[i] = nt; end
            end
            nxt = v + HO;
            if (nxt - 1 < T && en_a[nxt - 1]) ts = nxt;
            else running = 0;
         end
         if (running) break;
         c = nxt;
      end
   endtask

   // Put an echo pulse into the next rise window that starts at or after 'free'.
   task automatic place(input int delay, input int width, inout int free);
      int w;
      run_model(MAXT);
      w = -1;
      foreach (w0_q[i]) if (w < 0 && w0_q[i] >= free) w = w0_q[i];
      if (w < 0) begin
         chk("place_window_found", 0, 1);
         w = free;
      end
      if (width == 0) begin
         free = w + 1;
      end else begin
         for (int i = w + delay; i < w + delay + width && i < MAXT; i++) echo_a[i] = 1'b1;
         free = w + delay + width + 3;
      end
   endtask

   task automatic clear_stim(input bit en_val);
      for (int i = 0; i < MAXT; i++) begin en_a[i] = en_val; echo_a[i] = 1'b0; end
   endtask

   task automatic run_segment(input int T);
      dut_vc.delete(); dut_d.delete(); dut_t.delete();
      rise_q.delete(); fall_q.delete();
      checking = 1'b0;
      reset_n = 1'b0;
      enable = 1'b0;
      echo = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_trig", trig, 0);
      chk("rst_distance", distance, 255);
      chk("rst_valid", valid, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc = 0;
      enable = en_a[0];
      echo = echo_a[0];
      checking = 1'b1;
      for (int c = 1; c < T; c++) begin
         @(posedge clk);
         #1;
         cyc = c;
         enable = en_a[c];
         echo = echo_a[c];
      end
      @(posedge clk);
      #1;
      checking = 1'b0;
   endtask

   // single compare process, every cycle of a segment
   always @(negedge clk) begin
      if (checking) begin
         if (cyc == 0) prev_trig = 1'b0;
         n_tests++;
         if ({trig, busy, valid, timeout, distance} !==
             {exp_trig[cyc], exp_busy[cyc], exp_valid[cyc], exp_to[cyc], exp_dist[cyc]}) begin
            n_fail++;
            $display("FAIL cyc%0d outputs: got trig=%b busy=%b valid=%b timeout=%b distance=%0d, expected trig=%b busy=%b valid=%b timeout=%b distance=%0d",
                     cyc, trig, busy, valid, timeout, distance,
                     exp_trig[cyc], exp_busy[cyc], exp_valid[cyc], exp_to[cyc], exp_dist[cyc]);
         end
         if (valid) begin
            dut_vc.push_back(cyc);
            dut_d.push_back(int'(distance));
            dut_t.push_back(int'(timeout));
         end
         if (trig && !prev_trig) rise_q.push_back(cyc);
         if (!trig && prev_trig) fall_q.push_back(cyc);
         prev_trig = trig;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int free, T, w, vcount;
      int ed[6];
      int et[6];
      ed = '{3, 0, 1, 255, 255, 3};
      et = '{0, 0, 0, 0, 1, 0};

      // enable low: no trigger at all, echo noise ignored
      clear_stim(1'b0);
      for (int i = 0; i < 80; i++) echo_a[i] = 1'($urandom_range(0, 1));
      run_model(80);
      run_segment(80);
      chk("idle_trig_pulses", rise_q.size(), 0);
      chk("idle_valids", dut_vc.size(), 0);

      // basic, boundary widths, saturation, no-echo timeout, then random widths
      clear_stim(1'b1);
      free = 0;
      place(5, 35, free);
      place(5, 9, free);
      place(5, 10, free);
      place(3, 2600, free);
      place(0, 0, free);
      place(5, 35, free);
      for (int r = 0; r < 8; r++)
         place($urandom_range(0, 40), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 80), free);
      T = free + 80;
      run_model(T);
      run_segment(T);
      chk("s1_valid_count", dut_vc.size(), vc_q.size());
      if (dut_vc.size() >= 6 && rise_q.size() >= 2 && fall_q.size() >= 5) begin
         chk("s1_first_trig_rise", rise_q[0], 1);
         chk("s1_trig_width", fall_q[0] - rise_q[0], 4);
         chk("s1_first_valid_cycle", dut_vc[0], 48);
         chk("s1_holdoff_to_trig", rise_q[1] - dut_vc[0], 20);
         for (int i = 0; i < 6; i++) begin
            chk($sformatf("s1_dist%0d", i), dut_d[i], ed[i]);
            chk($sformatf("s1_timeout%0d", i), dut_t[i], et[i]);
         end
         chk("s1_noecho_latency", dut_vc[4] - fall_q[4], 50);
      end else begin
         chk("s1_events_present", 0, 1);
      end

      // echo stuck high: max-width timeout, then only a fresh rise counts
      clear_stim(1'b1);
      free = 0;
      place(5, 4000, free);
      place(5, 35, free);
      T = free + 30;
      run_model(T);
      run_segment(T);
      chk("s2_valid_count", dut_vc.size(), vc_q.size());
      if (dut_vc.size() >= 3 && fall_q.size() >= 2) begin
         chk("s2_stuck_dist", dut_d[0], 255);
         chk("s2_stuck_timeout", dut_t[0], 1);
         chk("s2_stuck_latency", dut_vc[0] - fall_q[0], 3007);
         chk("s2_level_ignored_latency", dut_vc[1] - fall_q[1], 50);
         chk("s2_level_ignored_timeout", dut_t[1], 1);
         chk("s2_last_dist", dut_d[dut_d.size() - 1], 3);
         chk("s2_last_timeout", dut_t[dut_t.size() - 1], 0);
      end else begin
         chk("s2_events_present", 0, 1);
      end

      // enable dropped during MEASURE
      clear_stim(1'b1);
      free = 0;
      place(5, 35, free);
      w = w0_q[0];
      for (int i = w + 20; i < MAXT; i++) en_a[i] = 1'b0;
      run_model(160);
      run_segment(160);
      chk("s3_valid_count", dut_vc.size(), 1);
      if (dut_vc.size() >= 1) begin
         chk("s3_dist", dut_d[0], 3);
         chk("s3_timeout", dut_t[0], 0);
      end
      chk("s3_trig_pulses", rise_q.size(), 1);
      chk("s3_busy_end", busy, 0);

      // reset pulsed mid-MEASURE of the second measurement
      clear_stim(1'b1);
      free = 0;
      place(5, 35, free);
      place(5, 35, free);
      run_model(MAXT);
      T = w0_q[1] + 25;
      run_model(T);
      run_segment(T);
      chk("s4_pre_dist", distance, 3);
      chk("s4_pre_busy", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("s4_async_trig", trig, 0);
      chk("s4_async_distance", distance, 255);
      chk("s4_async_busy", busy, 0);
      chk("s4_async_valid", valid, 0);
      chk("s4_async_timeout", timeout, 0);
      enable = 1'b0;
      vcount = 0;
      repeat (5) @(negedge clk) if (valid) vcount++;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (40) @(negedge clk) if (valid || busy) vcount++;
      chk("s4_no_valid_after_reset", vcount, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
